// File: rtl/bit_rev_pkg.sv
// Shared definitions for the bit-reversal datapath.
//   state_t   : sequencer states (COLLECT, LOAD0, LOAD1, SEND, DONE_CHK)
//   CH_0/CH_1 : ASCII '0' and '1', the only accepted keystrokes
//   NUM_BITS_DEF / MSG_LEN_DEF : default line geometry
//   IDX_W     : width of the bit index and the store address
package bit_rev_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        LOAD0,
        LOAD1,
        SEND,
        DONE_CHK
    } state_t;

    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_1 = 8'h31;

    localparam int NUM_BITS_DEF = 8;
    localparam int MSG_LEN_DEF  = 10;
    localparam int IDX_W        = 4;

    function automatic logic is_bit_key(input logic [7:0] b);
        return (b == CH_0) || (b == CH_1);
    endfunction

endpackage

// File: rtl/bit_line_printer.sv
// Keystroke controller and UART transmit sequencer for the bit-reversal
// datapath. Collects NUM_BITS ASCII '0'/'1' keystrokes into the external
// bit store, then reads store addresses 0..MSG_LEN-1 and streams the
// returned bytes to the UART transmitter under its busy handshake.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rx_data         : received byte, valid with new_rx_data
//   new_rx_data     : one-cycle receive strobe
//   tx_busy         : transmitter busy (sampled only in SEND, or for echo)
//   tx_data         : byte to transmit
//   new_tx_data     : one-cycle transmit strobe
//   ram_counter     : bit-store write index
//   ram_byte_in     : bit value to store
//   ram_wr          : bit-store write strobe
//   ram_addr        : bit-store read address
//   ram_data        : bit-store read data (registered, one clock after addr)
//
// Configuration macro: BIT_LINE_ECHO_EN -- when defined, each accepted
// keystroke is echoed to the transmitter in the same cycle as its ram_wr,
// provided tx_busy was low in the strobe cycle.
module bit_line_printer
    import bit_rev_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int MSG_LEN  = MSG_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             new_rx_data,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             new_tx_data,
    output logic [IDX_W-1:0] ram_counter,
    output logic             ram_byte_in,
    output logic             ram_wr,
    output logic [IDX_W-1:0] ram_addr,
    input  logic [7:0]       ram_data
);

    localparam logic [IDX_W-1:0] FULL_IDX  = IDX_W'(NUM_BITS);
    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(MSG_LEN - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    logic [IDX_W-1:0] ram_addr_n;
    logic [IDX_W-1:0] ram_counter_n;
    logic             ram_byte_in_n;
    logic             ram_wr_n;
    logic [7:0]       tx_data_n;
    logic             new_tx_data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            bit_idx     <= '0;
            ram_addr    <= '0;
            ram_counter <= '0;
            ram_byte_in <= 1'b0;
            ram_wr      <= 1'b0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            ram_addr    <= ram_addr_n;
            ram_counter <= ram_counter_n;
            ram_byte_in <= ram_byte_in_n;
            ram_wr      <= ram_wr_n;
            tx_data     <= tx_data_n;
            new_tx_data <= new_tx_data_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_idx_n     = bit_idx;
        ram_addr_n    = ram_addr;
        ram_counter_n = ram_counter;
        ram_byte_in_n = ram_byte_in;
        ram_wr_n      = 1'b0;
        tx_data_n     = tx_data;
        new_tx_data_n = 1'b0;

        case (state)
            COLLECT: begin
                // bit_idx reaches NUM_BITS in the cycle the last ram_wr is
                // on the bus; leaving here lets that write land before the
                // first read, and blocks a ninth keystroke.
                if (bit_idx == FULL_IDX) begin
                    state_n    = LOAD0;
                    ram_addr_n = '0;
                end else if (new_rx_data && is_bit_key(rx_data)) begin
                    ram_wr_n      = 1'b1;
                    ram_counter_n = bit_idx;
                    ram_byte_in_n = rx_data[0];
                    bit_idx_n     = bit_idx + 1'b1;
`ifdef BIT_LINE_ECHO_EN
                    if (!tx_busy) begin
                        tx_data_n     = rx_data;
                        new_tx_data_n = 1'b1;
                    end
`endif
                end
            end
            LOAD0: state_n = LOAD1;
            LOAD1: state_n = SEND;
            SEND: begin
                if (!tx_busy) begin
                    tx_data_n     = ram_data;
                    new_tx_data_n = 1'b1;
                    state_n       = DONE_CHK;
                end
            end
            DONE_CHK: begin
                if (ram_addr == LAST_ADDR) begin
                    ram_addr_n = '0;
                    bit_idx_n  = '0;
                    state_n    = COLLECT;
                end else begin
                    ram_addr_n = ram_addr + 1'b1;
                    state_n    = LOAD0;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

endmodule
